// File: rtl/buffer_demux_if.sv
// Bundle of upstream word/handshake and the four per-channel output words with their ready inputs.
// slave is the demux side; master is whoever drives upstream words and consumes the channels.
interface buffer_demux_if;
    logic [34:0] in_data;
    logic        in_ready;
    logic [34:0] out_data0;
    logic [34:0] out_data1;
    logic [34:0] out_data2;
    logic [34:0] out_data3;
    logic        ready0;
    logic        ready1;
    logic        ready2;
    logic        ready3;

    modport slave (
        input  in_data, ready0, ready1, ready2, ready3,
        output in_ready, out_data0, out_data1, out_data2, out_data3
    );

    modport master (
        output in_data, ready0, ready1, ready2, ready3,
        input  in_ready, out_data0, out_data1, out_data2, out_data3
    );
endinterface

// File: rtl/buffer_demux.sv
// Routes upstream words into four 4-deep per-channel FIFOs; any full FIFO stalls all input.
// Optional BUFFER_DEMUX_STATS_EN adds deliv_count, a wrapping count of delivered words.
//
// Handshake: a word moves on a rising edge when its valid bit and the receiver's ready are both
// high; in_ready depends only on FIFO occupancy and reset, never on in_data or the readyN inputs.
module buffer_demux (
    input  logic          clk,
    input  logic          reset,
    buffer_demux_if.slave bus,
    output logic          all_empty
`ifdef BUFFER_DEMUX_STATS_EN
    ,
    output logic [15:0]   deliv_count
`endif
);

    logic [31:0] mem_q    [4][4];
    logic [1:0]  wr_ptr_q [4];
    logic [1:0]  wr_ptr_d [4];
    logic [1:0]  rd_ptr_q [4];
    logic [1:0]  rd_ptr_d [4];
    logic [2:0]  cnt_q    [4];
    logic [2:0]  cnt_d    [4];
    logic [34:0] out_word [4];
    logic [3:0]  push;
    logic [3:0]  pop;
    logic [3:0]  full;
    logic [3:0]  rdy;
    logic        in_ready_w;
    logic        empty_w;

    assign rdy = {bus.ready3, bus.ready2, bus.ready1, bus.ready0};

    always_comb begin
        full       = '0;
        push       = '0;
        pop        = '0;
        empty_w    = 1'b1;
        for (int c = 0; c < 4; c++) begin
            full[c] = (cnt_q[c] == 3'd4);
        end
        in_ready_w = ~reset & ~(|full);
        for (int c = 0; c < 4; c++) begin
            push[c]     = bus.in_data[34] & in_ready_w & (bus.in_data[33:32] == 2'(c));
            pop[c]      = (cnt_q[c] != 3'd0) & rdy[c];
            wr_ptr_d[c] = wr_ptr_q[c] + {1'b0, push[c]};
            rd_ptr_d[c] = rd_ptr_q[c] + {1'b0, pop[c]};
            cnt_d[c]    = cnt_q[c] + {2'b00, push[c]} - {2'b00, pop[c]};
            // Empty channels present an all-zero word, not a stale head.
            out_word[c] = (cnt_q[c] != 3'd0) ? {1'b1, 2'(c), mem_q[c][rd_ptr_q[c]]} : 35'h0;
            empty_w     = empty_w & (cnt_q[c] == 3'd0);
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_data0 = out_word[0];
    assign bus.out_data1 = out_word[1];
    assign bus.out_data2 = out_word[2];
    assign bus.out_data3 = out_word[3];
    assign all_empty     = empty_w;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < 4; c++) begin
                wr_ptr_q[c] <= 2'd0;
                rd_ptr_q[c] <= 2'd0;
                cnt_q[c]    <= 3'd0;
            end
        end else begin
            for (int c = 0; c < 4; c++) begin
                wr_ptr_q[c] <= wr_ptr_d[c];
                rd_ptr_q[c] <= rd_ptr_d[c];
                cnt_q[c]    <= cnt_d[c];
            end
        end
    end

    // Storage needs no reset; push is already gated off while reset is high.
    always_ff @(posedge clk) begin
        for (int c = 0; c < 4; c++) begin
            if (push[c]) begin
                mem_q[c][wr_ptr_q[c]] <= bus.in_data[31:0];
            end
        end
    end

`ifdef BUFFER_DEMUX_STATS_EN
    logic [15:0] deliv_q;
    logic [15:0] deliv_d;
    logic [2:0]  pop_sum;

    always_comb begin
        pop_sum = {2'b00, pop[0]} + {2'b00, pop[1]} + {2'b00, pop[2]} + {2'b00, pop[3]};
        deliv_d = deliv_q + {13'd0, pop_sum};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            deliv_q <= 16'd0;
        end else begin
            deliv_q <= deliv_d;
        end
    end

    assign deliv_count = deliv_q;
`endif

endmodule
